// File: rtl/writeback_scheduler_if.sv
// writeback_scheduler_if
//   Bundles the writeback-stage signals: the ALU and memory-load requester
//   handshakes, the two register read ports and the writeback status outputs.
//   master : requester/datapath side (drives valids, dr, data, read addresses)
//   slave  : scheduler side (drives readies, read data, psr, status)
interface writeback_scheduler_if;
  logic        alu_valid;
  logic [2:0]  alu_dr;
  logic [15:0] alu_data;
  logic        alu_ready;

  logic        mem_valid;
  logic [2:0]  mem_dr;
  logic [15:0] mem_data;
  logic        mem_ready;

  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        enable_writeback;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;
  logic        wb_busy;

  modport master (
    output alu_valid, alu_dr, alu_data,
    input  alu_ready,
    output mem_valid, mem_dr, mem_data,
    input  mem_ready,
    output sr1, sr2,
    input  enable_writeback, VSR1, VSR2, psr, wb_busy
  );

  modport slave (
    input  alu_valid, alu_dr, alu_data,
    output alu_ready,
    input  mem_valid, mem_dr, mem_data,
    output mem_ready,
    input  sr1, sr2,
    output enable_writeback, VSR1, VSR2, psr, wb_busy
  );
endinterface

// File: rtl/writeback_scheduler.sv
// writeback_scheduler
//   Writeback-stage controller for the LC3 datapath. Owns the 8x16 register
//   file and arbitrates its single write port between the ALU result path and
//   the memory-load path, then holds off further writes for WB_GAP cycles.
//
//   Parameters
//     WB_GAP : idle cycles forced after each accepted write (0..15)
//     RR_EN  : 1 = round-robin on ties, 0 = memory path always wins ties
//   Ports
//     clock  : single clock, rising edge
//     reset  : synchronous, active-low
//     bus    : slave side of writeback_scheduler_if (handshakes, reads, status)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | readies may assert; a handshake writes the register file
//   GAP   | post-write turnaround, readies low, counter runs down to 0
module writeback_scheduler #(
  parameter int unsigned WB_GAP = 0,
  parameter bit          RR_EN  = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  writeback_scheduler_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_GAP    = 1'b1;
  localparam logic       GRANT_ALU = 1'b0;
  localparam logic       GRANT_MEM = 1'b1;
  localparam logic [3:0] GAP_LOAD  = (WB_GAP > 0) ? 4'(WB_GAP - 1) : 4'd0;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] rf_q [8];
  logic [15:0] vsr1_q, vsr1_d;
  logic [15:0] vsr2_q, vsr2_d;
  logic [2:0]  psr_q, psr_d;
  logic        wbe_q, wbe_d;

  logic        in_idle;
  logic        pick_mem;
  logic        alu_rdy;
  logic        mem_rdy;
  logic        wr_en;
  logic [2:0]  wr_dr;
  logic [15:0] wr_data;

  // Readies are held low during reset so a requester never sees a grant
  // that reset is about to discard; it keeps its request pending instead.
  assign in_idle  = reset && (state_q == ST_IDLE);
  // Memory wins when it is the only requester, when ties are fixed-priority,
  // or when the ALU took the previous write.
  assign pick_mem = bus.mem_valid &&
                    (!bus.alu_valid || !RR_EN || (last_grant_q == GRANT_ALU));
  assign alu_rdy  = in_idle && bus.alu_valid && !pick_mem;
  assign mem_rdy  = in_idle && pick_mem;

  assign wr_en    = alu_rdy || mem_rdy;
  assign wr_dr    = mem_rdy ? bus.mem_dr   : bus.alu_dr;
  assign wr_data  = mem_rdy ? bus.mem_data : bus.alu_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en && (WB_GAP != 0)) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    psr_d        = psr_q;
    last_grant_d = last_grant_q;
    wbe_d        = wr_en;
    if (wr_en) begin
      last_grant_d = mem_rdy ? GRANT_MEM : GRANT_ALU;
      if (wr_data[15]) begin
        psr_d = 3'b100;
      end else if (wr_data == 16'd0) begin
        psr_d = 3'b010;
      end else begin
        psr_d = 3'b001;
      end
    end
  end

  // Write-through: a read of the register being written this edge returns
  // the new value rather than the stale array contents.
  always_comb begin
    vsr1_d = rf_q[bus.sr1];
    vsr2_d = rf_q[bus.sr2];
    if (wr_en && (wr_dr == bus.sr1)) begin
      vsr1_d = wr_data;
    end
    if (wr_en && (wr_dr == bus.sr2)) begin
      vsr2_d = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= GRANT_MEM;
      vsr1_q       <= 16'd0;
      vsr2_q       <= 16'd0;
      psr_q        <= 3'b000;
      wbe_q        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'd0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      vsr1_q       <= vsr1_d;
      vsr2_q       <= vsr2_d;
      psr_q        <= psr_d;
      wbe_q        <= wbe_d;
      if (wr_en) begin
        rf_q[wr_dr] <= wr_data;
      end
    end
  end

  assign bus.alu_ready        = alu_rdy;
  assign bus.mem_ready        = mem_rdy;
  assign bus.enable_writeback = wbe_q;
  assign bus.VSR1             = vsr1_q;
  assign bus.VSR2             = vsr2_q;
  assign bus.psr              = psr_q;
  assign bus.wb_busy          = (state_q == ST_GAP);

endmodule

// File: doc/writeback_scheduler.md
# writeback_scheduler

Writeback-stage controller for the LC3 datapath. It owns the 8x16 general register file and arbitrates its single write port between the ALU result path and the memory-load result path using valid/ready handshakes. It drives the writeback_out bus signals enable_writeback, VSR1, VSR2 and psr, and enforces a configurable post-write gap that models pipeline turnaround.

## Interface
- WB_GAP, default 0: idle cycles forced after each accepted write. Legal range 0..15.
- RR_EN, default 1: 1 selects round-robin on ties; 0 selects fixed priority, with the memory path winning.

Clock and reset:
- clock  in  1  Single clock; all state changes on the rising edge.
- reset  in  1  Synchronous, active-low.

ALU and memory requesters:
- alu_valid  in  1  ALU result pending.
- alu_dr  in  3  ALU destination register.
- alu_data  in  16  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  Load result pending.
- mem_dr  in  3  Load destination register.
- mem_data  in  16  Load data.
- mem_ready  out  1  Memory request granted this cycle.

Register read and status:
- sr1  in  3  Read address, port 1.
- sr2  in  3  Read address, port 2.
- enable_writeback  out  1  One-cycle pulse marking a completed write.
- VSR1  out  16  Registered read of RF[sr1].
- VSR2  out  16  Registered read of RF[sr2].
- psr  out  3  {N,Z,P} of the last written value.
- wb_busy  out  1  High while the block is in GAP.

## Operation
- Reset values, on a clock edge with reset=0:
  - RF[0..7]=0, VSR1=0, VSR2=0, psr=3'b000.
  - enable_writeback=0, wb_busy=0, state=IDLE, gap counter=0.
  - last_grant=MEM, so the ALU wins the first tie.
- Reset overrides any in-flight handshake. A request presented during reset is not written.
- FSM states:
  - IDLE: readies may assert.
    - On a handshake with WB_GAP>0: go to GAP with counter=WB_GAP-1.
    - On a handshake with WB_GAP=0: stay in IDLE.
  - GAP: both readies are 0 and wb_busy=1. The counter decrements each cycle. When the counter is 0, return to IDLE.
- Grant is combinational, in IDLE only:
  - If only one requester is valid, it is granted.
  - If both are valid and RR_EN=1, the requester not equal to last_grant is granted.
  - If both are valid and RR_EN=0, mem is granted.
  - At most one ready is high in any cycle.
- Handshake means valid&&ready at a rising edge. At that edge:
  - RF[dr] <= data.
  - psr <= 3'b100 if data[15]; 3'b010 if data==0; otherwise 3'b001.
  - last_grant updates to the granted requester.
- Requesters hold valid, dr and data stable until their ready is seen.
- Reads:
  - VSR1 <= RF[sr1] and VSR2 <= RF[sr2] every cycle.
  - Write-through bypass: if the same edge writes RF[sr1] or RF[sr2], the new data is captured.
  - R0 is an ordinary register, not hardwired to zero.

## Timing
- enable_writeback is registered. It is high exactly in the cycle after a handshake edge, for one cycle per write.
- psr and the RF update become visible in that same following cycle.
- With WB_GAP=0, back-to-back writes are possible every cycle, so enable_writeback can stay high continuously.
- Write-to-write minimum spacing is 1+WB_GAP cycles.
- Read latency is 1 cycle, address to VSR1/VSR2.
- A request that arrives during GAP waits. It is granted in the first IDLE cycle.

## Test plan
- Reset release:
  - Stimulus: hold reset=0 for 2 cycles, then release.
  - Required: all outputs 0, psr=000. Reading sr1=3, sr2=7 gives VSR1=VSR2=0.
- Single ALU write:
  - Stimulus: alu_valid=1, alu_dr=3, alu_data=16'h8001, sr1=3.
  - Required: alu_ready=1 the same cycle. Next cycle enable_writeback=1, psr=100, VSR1=16'h8001 via bypass.
- Tie with RR_EN=1:
  - Stimulus: both requesters valid continuously, WB_GAP=0. ALU writes 0 to R1; mem writes 5 to R2.
  - Required: grants go ALU, MEM, ALU, ... Successive psr values alternate 010, 001.
- Fixed priority, RR_EN=0:
  - Stimulus: both requesters valid for 3 cycles.
  - Required: mem_ready=1 every cycle, alu_ready=0 throughout.
- Gap enforcement, WB_GAP=3:
  - Stimulus: ALU write to R4, then mem_valid asserted immediately.
  - Required: wb_busy high for 3 cycles with readies low. mem_ready rises in the 4th cycle after the first handshake.
- Reset mid-operation:
  - Stimulus: reset=0 in the cycle alu_valid=1 (dr=2, data=9).
  - Required: R2 stays 0, no enable_writeback pulse, state=IDLE.
